// File: rtl/hps2fpga_rw_arbiter.sv
// AXI3 read/write arbiter onto a single-port memory; one burst owns the port at a time.
// Optional beat address range check enabled by defining HPS2FPGA_ARB_ADDR_CHECK_EN.
module hps2fpga_rw_arbiter #(
  parameter logic [29:0] ADDR_LIMIT = 30'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] awid,
  input  logic [29:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic [11:0] wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [11:0] bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [11:0] arid,
  input  logic [29:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  output logic [11:0] rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR_BEAT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_e;

  state_e      state_q, state_d;
  logic        last_rd_q, last_rd_d;
  logic [11:0] id_q, id_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        dec_q, dec_d;
  logic        skip_q, skip_d;
  logic [31:0] rdata_q, rdata_d;

  logic        addr_bad;
  logic        unused_ok;

`ifdef HPS2FPGA_ARB_ADDR_CHECK_EN
  assign addr_bad  = (addr_q >= ADDR_LIMIT);
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid};
`else
  assign addr_bad  = 1'b0;
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid, ADDR_LIMIT};
`endif

  logic        grant_wr, grant_rd, last_beat, idle_ok;
  logic [29:0] next_addr;
  logic [1:0]  resp;

  // Contention goes to whichever channel did not win last time; reset leaves "read" as last.
  assign idle_ok   = rst_n && (state_q == IDLE);
  assign grant_wr  = idle_ok && awvalid && (!arvalid || last_rd_q);
  assign grant_rd  = idle_ok && arvalid && (!awvalid || !last_rd_q);
  assign last_beat = (cnt_q == len_q);
  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + 30'd4;
  assign resp      = dec_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);

  assign bid      = id_q;
  assign rid      = id_q;
  assign bresp    = resp;
  assign rresp    = resp;
  assign rdata    = rdata_q;
  assign mem_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    dec_d     = dec_q;
    skip_d    = skip_q;
    rdata_d   = rdata_q;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    case (state_q)
      IDLE: begin
        awready = grant_wr;
        arready = grant_rd;
        if (grant_wr) begin
          id_d      = awid;
          addr_d    = awaddr;
          len_d     = awlen;
          burst_d   = awburst;
          cnt_d     = 4'd0;
          err_d     = (awsize > 3'd2);
          skip_d    = (awsize > 3'd2);
          dec_d     = 1'b0;
          last_rd_d = 1'b0;
          state_d   = WR_BEAT;
        end else if (grant_rd) begin
          id_d      = arid;
          addr_d    = araddr;
          len_d     = arlen;
          burst_d   = arburst;
          cnt_d     = 4'd0;
          err_d     = (arsize > 3'd2);
          skip_d    = (arsize > 3'd2);
          dec_d     = 1'b0;
          rdata_d   = 32'h0;
          last_rd_d = 1'b1;
          state_d   = (arsize > 3'd2) ? RD_DATA : RD_REQ;
        end
      end
      WR_BEAT: begin
        mem_we    = 1'b1;
        mem_wdata = wdata;
        mem_be    = wstrb;
        // Beats that must not reach memory are still drained so the burst terminates.
        if (!skip_q && !addr_bad) begin
          mem_req = wvalid;
          wready  = mem_ready;
        end else begin
          wready  = 1'b1;
        end
        if (wvalid && wready) begin
          if (addr_bad) dec_d = 1'b1;
          if (wlast != last_beat) err_d = 1'b1;
          addr_d = next_addr;
          cnt_d  = cnt_q + 4'd1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      RD_REQ: begin
        if (addr_bad) begin
          dec_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = RD_DATA;
        end else begin
          mem_req = 1'b1;
          mem_be  = 4'hF;
          if (mem_ready) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        if (rready) begin
          cnt_d  = cnt_q + 4'd1;
          addr_d = next_addr;
          if (last_beat)   state_d = IDLE;
          else if (skip_q) state_d = RD_DATA;
          else             state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      id_q      <= 12'h0;
      addr_q    <= 30'h0;
      len_q     <= 4'h0;
      burst_q   <= 2'b00;
      cnt_q     <= 4'h0;
      err_q     <= 1'b0;
      dec_q     <= 1'b0;
      skip_q    <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dec_q     <= dec_d;
      skip_q    <= skip_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: doc/hps2fpga_rw_arbiter.md
HPS2FPGA_RW_ARBITER -- requirements
Module: hps2fpga_rw_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 30'h0001_0000, byte-address upper bound used by the address check (see Configuration).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 awid/awaddr/awlen/awsize/awburst/awvalid  input  12/30/4/3/2/1  AXI3 write address; awready output 1.
REQ-005 awlock/awcache/awprot, arlock/arcache/arprot  input  2/4/3  accepted and ignored.
REQ-006 wid/wdata/wstrb/wlast/wvalid  input  12/32/4/1/1  write data; wready output 1.
REQ-007 bid/bresp/bvalid  output  12/2/1  write response; bready input 1.
REQ-008 arid/araddr/arlen/arsize/arburst/arvalid  input  12/30/4/3/2/1  read address; arready output 1.
REQ-009 rid/rdata/rresp/rlast/rvalid  output  12/32/2/1/1  read data; rready input 1.
REQ-010 mem_req/mem_we/mem_addr/mem_wdata/mem_be  output  1/1/30/32/4  single-port memory request.
REQ-011 mem_ready  input  1  memory accepts request this cycle; mem_rvalid/mem_rdata  input  1/32  read return, latency >=1, in order.

Function
REQ-012 FSM states IDLE, WR_BEAT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA; one burst owns the memory port at a time.
REQ-013 IDLE: awvalid only -> grant write; arvalid only -> grant read; both -> grant opposite of last_grant flop (round-robin, burst granularity).
REQ-014 awready/arready high only in IDLE, for the granted channel only (combinational); handshake latches id/addr/len/size/burst, updates last_grant, moves to WR_BEAT or RD_REQ.
REQ-015 WR_BEAT: mem_req=wvalid, mem_we=1, mem_wdata=wdata, mem_be=wstrb, wready=mem_ready; beat completes on wvalid&&wready.
REQ-016 Address per beat: INCR(01) and WRAP(10) add 4, FIXED(00) holds; 30-bit wrap-around modulo 2^30.
REQ-017 Beat counter 4-bit; write burst ends at beat awlen (awlen+1 beats) -> WR_RESP; wlast on an earlier beat or absent on the final beat sets error flag, burst still ends at awlen+1 beats.
REQ-018 WR_RESP: bvalid=1, bid=latched awid, bresp=2'b10 (SLVERR) if error flag else 2'b00; bvalid&&bready -> IDLE.
REQ-019 awsize>2 or arsize>2: error flag set at address handshake; memory not accessed (mem_req=0), wready=1 to drain write beats, read beats return rdata=0 via RD_DATA skipping RD_REQ/RD_WAIT.
REQ-020 RD_REQ: mem_req=1, mem_we=0, mem_be=4'hF; mem_ready -> RD_WAIT.
REQ-021 RD_WAIT: mem_rvalid captures mem_rdata into rdata register -> RD_DATA; mem_rvalid in any other state is ignored.
REQ-022 RD_DATA: rvalid=1, rid=latched arid, rresp=2'b10 if error flag else 2'b00, rlast=1 on beat arlen; rvalid&&rready -> RD_REQ (more beats), else IDLE.
REQ-023 Outputs in AXI/memory handshake states are stable until accepted; no new address accepted before B or final R handshake completes.

Reset
REQ-024 rst_n low: state=IDLE, last_grant=read (first contention grants write), counters/flags 0.
REQ-025 Reset values: awready=arready=wready=bvalid=rvalid=rlast=mem_req=mem_we=0; bid/bresp/rid/rresp/rdata/mem_addr/mem_wdata/mem_be all 0.
REQ-026 Reset mid-burst abandons the burst immediately; no response issued after release.

Configuration
REQ-027 Macro HPS2FPGA_ARB_ADDR_CHECK_EN defined: any beat address >= ADDR_LIMIT sets error flag, that beat skips memory access, response DECERR 2'b11 (overrides SLVERR).
REQ-028 Macro undefined: no address check, all addresses forwarded, ADDR_LIMIT unused.

Verification
REQ-029 Write awaddr=0x100, awlen=3, INCR, mem_ready=1 -> mem_addr 0x100,0x104,0x108,0x10C, bresp=00, bid=awid.
REQ-030 awvalid and arvalid both high from reset, each len=0 -> write granted first, then read; repeated contention alternates W,R,W,R.
REQ-031 Read araddr=0x40, arlen=1, FIXED, mem latency 3, rready low 2 cycles -> both beats at mem_addr 0x40, rvalid held, rlast only on beat 1.
REQ-032 Write awlen=2 with wlast on beat 1 -> 3 beats consumed, bresp=10; awsize=3 -> no mem_req, bresp=10.
REQ-033 With HPS2FPGA_ARB_ADDR_CHECK_EN, read araddr=ADDR_LIMIT -> no mem_req, rresp=11; without macro -> mem_req issued, rresp=00.
REQ-034 rst_n low during WR_BEAT beat 2 -> all outputs at reset values same cycle; new write after release completes normally.
